// File: rtl/normaliser_pkg.sv
// Shared types for the senone score normaliser.
// Score format, SRAM address width and FSM encoding.
package normaliser_pkg;

    typedef logic signed [15:0] num;

    localparam int SRAM_AW = 21;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_CALC,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_e;

endpackage

// File: rtl/normaliser_if.sv
// Byte-wide SRAM request/ack bus.
// The normaliser is the master; the SRAM arbiter is the slave.
interface normaliser_if;
    import normaliser_pkg::*;

    logic               norm_sram_read;
    logic               norm_sram_write;
    logic [SRAM_AW-1:0] norm_sram_addr;
    logic [7:0]         norm_sram_data;
    logic [7:0]         sram_rdata;
    logic               sram_ack;

    modport master (
        output norm_sram_read,
        output norm_sram_write,
        output norm_sram_addr,
        output norm_sram_data,
        input  sram_rdata,
        input  sram_ack
    );

    modport slave (
        input  norm_sram_read,
        input  norm_sram_write,
        input  norm_sram_addr,
        input  norm_sram_data,
        output sram_rdata,
        output sram_ack
    );

endinterface

// File: rtl/normaliser_sat_sub16.sv
// Signed 16-bit a - b, clamped to the 16-bit signed range.
// Overflow shows up as bits 16 and 15 of the 17-bit difference disagreeing.
module sat_sub16
    import normaliser_pkg::*;
(
    input  num i_a,
    input  num i_b,
    output num o_y
);

    logic [16:0] w_diff;
    logic        w_ovf;

    assign w_diff = {i_a[15], i_a} - {i_b[15], i_b};
    assign w_ovf  = w_diff[16] ^ w_diff[15];

    // Clamp toward the sign of the true 17-bit result on overflow.
    always_comb begin
        o_y = num'(w_diff[15:0]);
        if (w_ovf) begin
            o_y = w_diff[16] ? 16'sh8000 : 16'sh7FFF;
        end
    end

endmodule

// File: rtl/normaliser.sv
// Rewrites each senone score in SRAM as score - best, saturated.
// One read-modify-write pass over N_SENONES little-endian 16-bit words.
module normaliser
    import normaliser_pkg::*;
#(
    parameter int N_SENONES = 10,
    parameter int BASE_ADDR = 0
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start_norm,
    input  num                  best_score,
    output logic                norm_done,
    normaliser_if.master        bus
);

    state_e             r_state;
    state_e             w_next;
    logic [7:0]         r_idx;
    num                 r_best;
    num                 r_result;
    logic [7:0]         r_lo;
    logic [7:0]         r_hi;
    num                 w_score;
    num                 w_diff;
    logic [SRAM_AW-1:0] w_base;
    logic               w_last;

    assign w_score = num'({r_hi, r_lo});
    assign w_base  = SRAM_AW'(BASE_ADDR)
                   + {{(SRAM_AW-9){1'b0}}, r_idx, 1'b0};
    assign w_last  = (r_idx == 8'(N_SENONES - 1));

    sat_sub16 u_sat_sub16 (
        .i_a (w_score),
        .i_b (r_best),
        .o_y (w_diff)
    );

    // State register; reset abandons any sweep in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: each SRAM state waits on ack, CALC takes one cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start_norm)   w_next = S_RD_LO;
            S_RD_LO: if (bus.sram_ack) w_next = S_RD_HI;
            S_RD_HI: if (bus.sram_ack) w_next = S_CALC;
            S_CALC:                    w_next = S_WR_LO;
            S_WR_LO: if (bus.sram_ack) w_next = S_WR_HI;
            S_WR_HI: begin
                if (bus.sram_ack) begin
                    w_next = w_last ? S_DONE : S_RD_LO;
                end
            end
            S_DONE:                    w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    // Datapath: latch best at start, gather bytes, register the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx    <= '0;
            r_best   <= '0;
            r_result <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
        end else begin
            if (r_state == S_IDLE && start_norm) begin
                r_best <= best_score;
                r_idx  <= '0;
            end
            if (r_state == S_RD_LO && bus.sram_ack) begin
                r_lo <= bus.sram_rdata;
            end
            if (r_state == S_RD_HI && bus.sram_ack) begin
                r_hi <= bus.sram_rdata;
            end
            if (r_state == S_CALC) begin
                r_result <= w_diff;
            end
            if (r_state == S_WR_HI && bus.sram_ack && !w_last) begin
                r_idx <= r_idx + 8'd1;
            end
        end
    end

    // Outputs decoded from state so requests hold steady until ack.
    always_comb begin
        norm_done           = 1'b0;
        bus.norm_sram_read  = 1'b0;
        bus.norm_sram_write = 1'b0;
        bus.norm_sram_addr  = '0;
        bus.norm_sram_data  = '0;
        unique case (r_state)
            S_RD_LO: begin
                bus.norm_sram_read = 1'b1;
                bus.norm_sram_addr = w_base;
            end
            S_RD_HI: begin
                bus.norm_sram_read = 1'b1;
                bus.norm_sram_addr = w_base + SRAM_AW'(1);
            end
            S_WR_LO: begin
                bus.norm_sram_write = 1'b1;
                bus.norm_sram_addr  = w_base;
                bus.norm_sram_data  = r_result[7:0];
            end
            S_WR_HI: begin
                bus.norm_sram_write = 1'b1;
                bus.norm_sram_addr  = w_base + SRAM_AW'(1);
                bus.norm_sram_data  = r_result[15:8];
            end
            S_DONE: begin
                norm_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_normaliser.sv
// Bench for normaliser: SRAM model with programmable ack delay,
// write scoreboard fed by the stimulus and drained by the SRAM monitor.
module tb_normaliser;
    import normaliser_pkg::*;

    localparam int BASE = 'h40;

    typedef struct {
        logic [SRAM_AW-1:0] a;
        logic [7:0]         d;
    } wr_t;

    logic clk;
    logic reset;
    logic start_norm;
    num   best_score;
    logic norm_done;

    normaliser_if sif ();

    normaliser #(
        .N_SENONES (3),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_norm (start_norm),
        .best_score (best_score),
        .norm_done  (norm_done),
        .bus        (sif)
    );

    logic [7:0]         mem [0:255];
    wr_t                sb [$];
    int                 n_chk;
    int                 n_fail;
    int                 cyc;
    int                 n_done;
    int                 done_cyc;
    int                 req_cnt;
    int                 dly_mode;
    bit                 spur;
    bit                 pend;
    int                 cnt;
    int                 dly;
    logic [SRAM_AW-1:0] p_addr;
    logic [7:0]         p_data;
    logic               p_wr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int pick();
        if (dly_mode == 0) return 0;
        if (dly_mode == 1) return int'($urandom_range(7, 0));
        return 3;
    endfunction

    // SRAM model and scoreboard monitor, on the falling edge.
    always @(negedge clk) begin
        wr_t e;
        sif.sram_ack = 1'b0;
        if (!reset) begin
            pend = 1'b0;
        end else begin
            if (norm_done) begin
                n_done++;
                done_cyc = cyc;
            end
            chk("rd_wr_excl",
                32'(sif.norm_sram_read & sif.norm_sram_write), 0);
            if (sif.norm_sram_read || sif.norm_sram_write) begin
                req_cnt++;
                if (!pend) begin
                    pend   = 1'b1;
                    p_addr = sif.norm_sram_addr;
                    p_data = sif.norm_sram_data;
                    p_wr   = sif.norm_sram_write;
                    cnt    = 0;
                    dly    = pick();
                end else begin
                    chk("addr_stable", 32'(sif.norm_sram_addr), 32'(p_addr));
                    chk("kind_stable", 32'(sif.norm_sram_write), 32'(p_wr));
                    if (p_wr) begin
                        chk("data_stable", 32'(sif.norm_sram_data),
                            32'(p_data));
                    end
                end
                if (cnt >= dly) begin
                    sif.sram_ack = 1'b1;
                    pend = 1'b0;
                    if (sif.norm_sram_write) begin
                        mem[sif.norm_sram_addr[7:0]] = sif.norm_sram_data;
                        if (sb.size() == 0) begin
                            chk("sb_unexpected_write", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            chk("wr_addr", 32'(sif.norm_sram_addr), 32'(e.a));
                            chk("wr_data", 32'(sif.norm_sram_data), 32'(e.d));
                        end
                    end else begin
                        sif.sram_rdata = mem[sif.norm_sram_addr[7:0]];
                    end
                end else begin
                    cnt++;
                end
            end else if (spur) begin
                sif.sram_ack   = 1'($urandom_range(1, 0));
                sif.sram_rdata = 8'($urandom_range(255, 0));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input num v0, input num v1, input num v2);
        num v [3];
        v = '{v0, v1, v2};
        for (int i = 0; i < 3; i++) begin
            mem[BASE + 2*i]     = v[i][7:0];
            mem[BASE + 2*i + 1] = v[i][15:8];
        end
    endtask

    task automatic push_exp(input num e0, input num e1, input num e2);
        num  v [3];
        wr_t w;
        v = '{e0, e1, e2};
        for (int i = 0; i < 3; i++) begin
            w.a = SRAM_AW'(BASE + 2*i);
            w.d = v[i][7:0];
            sb.push_back(w);
            w.a = SRAM_AW'(BASE + 2*i + 1);
            w.d = v[i][15:8];
            sb.push_back(w);
        end
    endtask

    function automatic logic [15:0] word(input int i);
        return {mem[BASE + 2*i + 1], mem[BASE + 2*i]};
    endfunction

    task automatic chk_mem(input string nm, input num e0, input num e1,
                           input num e2);
        chk({nm, "_w0"}, 32'(word(0)), 32'($unsigned(e0)));
        chk({nm, "_w1"}, 32'(word(1)), 32'($unsigned(e1)));
        chk({nm, "_w2"}, 32'(word(2)), 32'($unsigned(e2)));
    endtask

    task automatic wait_done(input int target, input string nm,
                             input bit tog);
        int k;
        k = 0;
        while (n_done < target && k < 2000) begin
            tick();
            if (tog) best_score = ~best_score;
            k++;
        end
        chk({nm, "_timeout"}, 32'(n_done >= target), 1);
    endtask

    task automatic sweep(input string nm, input num b, input bit tog,
                         input int lat);
        int d0;
        int st;
        tick();
        best_score = b;
        start_norm = 1'b1;
        st = cyc;
        d0 = n_done;
        tick();
        start_norm = 1'b0;
        wait_done(d0 + 1, nm, tog);
        if (lat > 0) chk({nm, "_latency"}, 32'(done_cyc - st), 32'(lat));
        tick();
        tick();
        chk({nm, "_done_once"}, 32'(n_done - d0), 1);
        chk({nm, "_sb_drained"}, 32'(sb.size()), 0);
    endtask

    initial begin
        int  d0;
        int  snap;
        bit  found;
        reset      = 1'b0;
        start_norm = 1'b0;
        best_score = '0;
        dly_mode   = 0;
        spur       = 1'b0;
        n_chk      = 0;
        n_fail     = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        repeat (3) tick();
        chk("rst_read", 32'(sif.norm_sram_read), 0);
        chk("rst_write", 32'(sif.norm_sram_write), 0);
        chk("rst_addr", 32'(sif.norm_sram_addr), 0);
        chk("rst_data", 32'(sif.norm_sram_data), 0);
        chk("rst_done", 32'(norm_done), 0);
        reset = 1'b1;
        tick();

        // Basic sweep, single-cycle ack.
        load(-16'sd100, -16'sd50, -16'sd200);
        push_exp(-16'sd50, 16'sd0, -16'sd150);
        sweep("basic", -16'sd50, 1'b0, 16);
        chk_mem("basic", -16'sd50, 16'sd0, -16'sd150);

        // start held across DONE, best changed for the second sweep.
        push_exp(16'sd0, 16'sd50, -16'sd100);
        push_exp(16'sd10, 16'sd60, -16'sd90);
        tick();
        best_score = -16'sd50;
        start_norm = 1'b1;
        d0 = n_done;
        wait_done(d0 + 1, "held1", 1'b0);
        best_score = -16'sd10;
        tick();
        tick();
        start_norm = 1'b0;
        wait_done(d0 + 2, "held2", 1'b0);
        tick();
        chk("held_done_cnt", 32'(n_done - d0), 2);
        chk("held_sb_drained", 32'(sb.size()), 0);
        chk_mem("held", 16'sd10, 16'sd60, -16'sd90);

        // Saturation both ways.
        load(16'sh8000, 16'sh0001, 16'sh7FFF);
        push_exp(16'sh8000, 16'sh8002, 16'sh0000);
        sweep("sat_neg", 16'sh7FFF, 1'b0, 16);
        chk_mem("sat_neg", 16'sh8000, 16'sh8002, 16'sh0000);
        load(16'sh7FFF, 16'shFFFF, 16'sh8000);
        push_exp(16'sh7FFF, 16'sh7FFF, 16'sh0000);
        sweep("sat_pos", 16'sh8000, 1'b0, 16);
        chk_mem("sat_pos", 16'sh7FFF, 16'sh7FFF, 16'sh0000);

        // Random ack delays plus stray acks between requests.
        dly_mode = 1;
        spur     = 1'b1;
        load(-16'sd100, -16'sd50, -16'sd200);
        push_exp(-16'sd50, 16'sd0, -16'sd150);
        sweep("rnd", -16'sd50, 1'b0, 0);
        chk_mem("rnd", -16'sd50, 16'sd0, -16'sd150);
        spur     = 1'b0;
        dly_mode = 0;

        // best_score toggling after the latch.
        load(16'sd100, 16'sd200, 16'sd300);
        push_exp(16'sd80, 16'sd180, 16'sd280);
        sweep("toggle", 16'sd20, 1'b1, 16);
        chk_mem("toggle", 16'sd80, 16'sd180, 16'sd280);

        // Reset during WR_HI of senone 1.
        dly_mode = 2;
        load(16'sd1000, 16'sd2000, 16'sd3000);
        push_exp(16'sd500, 16'sd1500, 16'sd2500);
        tick();
        best_score = 16'sd500;
        start_norm = 1'b1;
        tick();
        start_norm = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            tick();
            if (sif.norm_sram_write &&
                sif.norm_sram_addr == SRAM_AW'(BASE + 3)) found = 1'b1;
        end
        chk("reach_wr_hi", 32'(found), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_read", 32'(sif.norm_sram_read), 0);
        chk("arst_write", 32'(sif.norm_sram_write), 0);
        chk("arst_addr", 32'(sif.norm_sram_addr), 0);
        chk("arst_data", 32'(sif.norm_sram_data), 0);
        chk("arst_done", 32'(norm_done), 0);
        sb.delete();
        tick();
        tick();
        reset = 1'b1;
        snap = req_cnt;
        repeat (20) tick();
        chk("no_req_after_rst", 32'(req_cnt), 32'(snap));
        chk_mem("partial", 16'sd500, 16'sh07DC, 16'sd3000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/normaliser.md
NORMALISER -- requirements
Module: normaliser

Interface
REQ-001 Parameter N_SENONES, default 10, number of senone scores to normalise (legal range 1..255).
REQ-002 Parameter BASE_ADDR, default 0, SRAM byte address of senone 0's score.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start_norm  input  1  level request from the top-level FSM; sampled only in IDLE.
REQ-006 best_score  input  16 (num, signed)  maximum senone score from the maximiser; latched at start.
REQ-007 norm_done  output  1  one-cycle pulse when all N_SENONES scores have been rewritten.
REQ-008 norm_sram_read  output  1  SRAM read request, held until ack.
REQ-009 norm_sram_write  output  1  SRAM write request, held until ack.
REQ-010 norm_sram_addr  output  21  SRAM byte address for the current request.
REQ-011 norm_sram_data  output  8  write data byte, valid while norm_sram_write is high.
REQ-012 sram_rdata  input  8  read data, valid in the cycle sram_ack is high for a read.
REQ-013 sram_ack  input  1  one-cycle completion strobe for the outstanding read or write.

Function
REQ-014 Score i is stored little-endian: low byte at BASE_ADDR+2i, high byte at BASE_ADDR+2i+1.
REQ-015 FSM states: IDLE, RD_LO, RD_HI, CALC, WR_LO, WR_HI, DONE.
REQ-016 IDLE->RD_LO when start_norm=1; in the same edge, latch best_score and clear the index counter idx to 0.
REQ-017 RD_LO: assert read at 2idx; on ack, capture sram_rdata as the low byte and go to RD_HI.
REQ-018 RD_HI: assert read at 2idx+1; on ack, capture the high byte and go to CALC.
REQ-019 CALC (one cycle): compute result = score - latched best as 17-bit signed, saturate to [-32768, 32767], and register it.
REQ-020 WR_LO: write result[7:0] to 2idx; on ack go to WR_HI.
REQ-021 WR_HI: write result[15:8] to 2idx+1; on ack, go to DONE if idx = N_SENONES-1, else increment idx and go to RD_LO.
REQ-022 DONE: pulse norm_done for exactly one cycle, then return to IDLE.
REQ-023 Without ack, a request stays asserted with stable address and data indefinitely; no timeout.
REQ-024 norm_sram_read and norm_sram_write are never high together, and are low in IDLE, CALC and DONE.
REQ-025 An ack received while no request is outstanding is ignored.
REQ-026 Deasserting start_norm mid-operation does not abort; the sweep completes.
REQ-027 start_norm held high in the cycle after DONE starts a new sweep, with best_score re-latched.
REQ-028 Changes on best_score after latching have no effect on the sweep in progress.
REQ-029 Minimum latency with single-cycle ack: 5 cycles per senone plus 1 DONE cycle after start.

Reset
REQ-030 On reset low, asynchronously: state=IDLE, idx=0, latched best=0, result=0, norm_done=0, norm_sram_read=0, norm_sram_write=0, norm_sram_addr=0, norm_sram_data=0.
REQ-031 A reset asserted mid-sweep abandons the sweep with no further SRAM requests; partially written scores are not restored.

Structure
REQ-032 The num typedef (signed 16-bit), the SRAM address width constant (21) and the state enum belong in the shared project package.
REQ-033 Saturating subtraction is the single sub-module, named sat_sub16 (combinational, 16-bit signed in, 16-bit signed out).

Verification
REQ-034 Bench SRAM model with 1-cycle ack preloaded with scores {-100, -50, -200, ...}, N=3, best=-50 -> memory holds {-50, 0, -150}; norm_done pulses once, 16 cycles after start.
REQ-035 Score 0x8000, best 0x7FFF -> stored 0x8000 (saturated); score 0x7FFF, best 0x8000 -> stored 0x7FFF.
REQ-036 Ack delayed 0-7 random cycles per request -> identical final memory; address and data stable while each request is pending; read and write never high together.
REQ-037 Reset pulsed low during WR_HI of senone 1 -> all outputs 0 within the same cycle; no request after reset until the next start_norm.
REQ-038 start_norm held high across DONE, with best changed from -50 to -10 -> second sweep applies -10 to the already normalised values.
REQ-039 best_score toggled every cycle after start -> results use only the latched value.
